// File: rtl/crc4_pkg.sv
// rtl/crc4_pkg.sv - shared CRC-4 constants and byte-parallel update function
package crc4_pkg;

    localparam logic [3:0] CRC4_INIT = 4'hF;
    localparam logic [3:0] CRC4_POLY = 4'hD;

    // One byte per step, x^4+x^3+x^2+1, MSB-first, no reflection
    function automatic logic [3:0] crc4_next(input logic [3:0] q, input logic [7:0] d);
        logic [3:0] n;
        n[0] = q[3] ^ d[0] ^ d[1] ^ d[3] ^ d[7];
        n[1] = q[0] ^ d[1] ^ d[2] ^ d[4];
        n[2] = q[1] ^ q[3] ^ d[0] ^ d[1] ^ d[2] ^ d[5] ^ d[7];
        n[3] = q[2] ^ q[3] ^ d[0] ^ d[2] ^ d[6] ^ d[7];
        return n;
    endfunction

endpackage

// File: rtl/crc4_frame_checker.sv
// rtl/crc4_frame_checker.sv - strips the trailing CRC beat, forwards payload, reports per-frame CRC status
module crc4_frame_checker
    import crc4_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic             chk_valid,
    output logic             chk_ok,
    output logic             chk_runt,
    output logic [LEN_W-1:0] chk_len
);

    logic [7:0]       hold_q, hold_d;
    logic             hv_q, hv_d;
    logic             m_valid_q, m_valid_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_last_q, m_last_d;
    logic [3:0]       crc_q, crc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             chk_valid_q, chk_valid_d;
    logic             chk_ok_q, chk_ok_d;
    logic             chk_runt_q, chk_runt_d;
    logic [LEN_W-1:0] chk_len_q, chk_len_d;

    logic accept;

    // The held byte can only move out when the output slot is free or draining
    assign s_ready = !hv_q || !m_valid_q || m_ready;
    assign accept  = s_valid && s_ready;

    always_comb begin
        hold_d      = hold_q;
        hv_d        = hv_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        crc_d       = crc_q;
        len_d       = len_q;
        chk_valid_d = 1'b0;
        chk_ok_d    = chk_ok_q;
        chk_runt_d  = chk_runt_q;
        chk_len_d   = chk_len_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (accept && hv_q) begin
            m_valid_d = 1'b1;
            m_data_d  = hold_q;
            m_last_d  = s_last;
        end

        if (accept && !s_last) begin
            hold_d = s_data;
            hv_d   = 1'b1;
            crc_d  = crc4_next(crc_q, s_data);
            len_d  = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + 1'b1;
        end

        if (accept && s_last) begin
            hv_d        = 1'b0;
            crc_d       = CRC4_INIT;
            len_d       = '0;
            chk_valid_d = 1'b1;
            if (hv_q) begin
                chk_ok_d   = (crc_q == s_data[3:0]) && (s_data[7:4] == 4'h0);
                chk_runt_d = 1'b0;
                chk_len_d  = len_q;
            end else begin
                chk_ok_d   = 1'b0;
                chk_runt_d = 1'b1;
                chk_len_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= 8'h00;
            hv_q        <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= 8'h00;
            m_last_q    <= 1'b0;
            crc_q       <= CRC4_INIT;
            len_q       <= '0;
            chk_valid_q <= 1'b0;
            chk_ok_q    <= 1'b0;
            chk_runt_q  <= 1'b0;
            chk_len_q   <= '0;
        end else begin
            hold_q      <= hold_d;
            hv_q        <= hv_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            chk_valid_q <= chk_valid_d;
            chk_ok_q    <= chk_ok_d;
            chk_runt_q  <= chk_runt_d;
            chk_len_q   <= chk_len_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign chk_valid = chk_valid_q;
    assign chk_ok    = chk_ok_q;
    assign chk_runt  = chk_runt_q;
    assign chk_len   = chk_len_q;

endmodule

// File: tb/tb_crc4_frame_checker.sv
// tb/tb_crc4_frame_checker.sv - directed self-checking bench for crc4_frame_checker
module tb_crc4_frame_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic        m_last;
    logic        chk_valid;
    logic        chk_ok;
    logic        chk_runt;
    logic [15:0] chk_len;

    int checks = 0;
    int failures = 0;

    logic [8:0]  beats[$];
    logic [17:0] chks[$];
    int          stab_err = 0;
    int          sready_low = 0;
    logic        prev_stall = 1'b0;
    logic [9:0]  prev_bus = '0;

    crc4_frame_checker #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .chk_valid(chk_valid), .chk_ok(chk_ok), .chk_runt(chk_runt), .chk_len(chk_len)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && ({m_valid, m_last, m_data} !== prev_bus)) stab_err++;
            if (m_valid && m_ready) beats.push_back({m_last, m_data});
            if (chk_valid) chks.push_back({chk_ok, chk_runt, chk_len});
            if (!s_ready) sready_low++;
            prev_stall = m_valid && !m_ready;
            prev_bus   = {m_valid, m_last, m_data};
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int budget;
        bit done;
        budget = 100;
        done = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!done && budget > 0) begin
            @(negedge clk);
            if (s_ready) done = 1'b1;
            @(posedge clk);
            #1;
            budget--;
        end
        s_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: s_ready stayed 0 for byte %02h, required acceptance", d);
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        beats.delete();
        chks.delete();
        stab_err = 0;
        sready_low = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_valid, m_data, m_last} !== 10'h000) begin
            failures++;
            $display("FAIL reset_m: got v=%b d=%02h l=%b, required 0/00/0", m_valid, m_data, m_last);
        end
        checks++;
        if ({chk_valid, chk_ok, chk_runt, chk_len} !== 19'h0) begin
            failures++;
            $display("FAIL reset_chk: got v=%b ok=%b runt=%b len=%0d, required all 0", chk_valid, chk_ok, chk_runt, chk_len);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_s_ready: got %b, required 1", s_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_single();
        clear_q();
        send(8'h00, 1'b0);
        send(8'h03, 1'b1);
        idle(4);
        checks++;
        if (beats.size() != 1 || beats[0] !== 9'h100) begin
            failures++;
            $display("FAIL single_beats: got n=%0d first=%h, required 1 beat 100", beats.size(), beats.size() > 0 ? beats[0] : 9'h0);
        end
        checks++;
        if (chks.size() != 1 || chks[0] !== {1'b1, 1'b0, 16'd1}) begin
            failures++;
            $display("FAIL single_chk: got n=%0d st=%h, required 1 status ok len 1", chks.size(), chks.size() > 0 ? chks[0] : 18'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_b[3];
        exp_b[0] = 9'h000;
        exp_b[1] = 9'h100;
        exp_b[2] = 9'h1FF;
        clear_q();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h06, 1'b1);
        send(8'hFF, 1'b0);
        send(8'h05, 1'b1);
        idle(4);
        checks++;
        if (beats.size() != 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d beats, required 3", beats.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (beats[i] !== exp_b[i]) begin
                    failures++;
                    $display("FAIL b2b_beat%0d: got %h, required %h", i, beats[i], exp_b[i]);
                end
            end
        end
        checks++;
        if (chks.size() != 2 || chks[0] !== {1'b1, 1'b0, 16'd2} || chks[1] !== {1'b1, 1'b0, 16'd1}) begin
            failures++;
            $display("FAIL b2b_chk: got n=%0d, required ok/len2 then ok/len1", chks.size());
        end
    endtask

    task automatic test_bad_crc();
        clear_q();
        send(8'hFF, 1'b0);
        send(8'h04, 1'b1);
        send(8'hFF, 1'b0);
        send(8'h15, 1'b1);
        idle(4);
        checks++;
        if (beats.size() != 2 || beats[0] !== 9'h1FF || beats[1] !== 9'h1FF) begin
            failures++;
            $display("FAIL bad_beats: got n=%0d, required two 1FF beats", beats.size());
        end
        checks++;
        if (chks.size() != 2 || chks[0] !== {1'b0, 1'b0, 16'd1} || chks[1] !== {1'b0, 1'b0, 16'd1}) begin
            failures++;
            $display("FAIL bad_chk: got n=%0d st0=%h, required two not-ok len 1", chks.size(), chks.size() > 0 ? chks[0] : 18'h0);
        end
    endtask

    task automatic test_runt();
        clear_q();
        send(8'h0F, 1'b1);
        idle(4);
        checks++;
        if (beats.size() != 0) begin
            failures++;
            $display("FAIL runt_beats: got %0d beats, required 0", beats.size());
        end
        checks++;
        if (chks.size() != 1 || chks[0] !== {1'b0, 1'b1, 16'd0}) begin
            failures++;
            $display("FAIL runt_chk: got n=%0d st=%h, required runt ok=0 len 0", chks.size(), chks.size() > 0 ? chks[0] : 18'h0);
        end
        checks++;
        if (chk_runt !== 1'b1 || chk_ok !== 1'b0) begin
            failures++;
            $display("FAIL runt_hold: got ok=%b runt=%b after pulse, required 0/1", chk_ok, chk_runt);
        end
    endtask

    task automatic test_backpressure();
        clear_q();
        fork
            begin
                for (int i = 1; i <= 6; i++) send(i[7:0], 1'b0);
                send(8'h07, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                m_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        idle(4);
        checks++;
        if (beats.size() != 6) begin
            failures++;
            $display("FAIL bp_count: got %0d beats, required 6", beats.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (beats[i] !== {(i == 5), 8'(i + 1)}) begin
                    failures++;
                    $display("FAIL bp_beat%0d: got %h, required %h", i, beats[i], {(i == 5), 8'(i + 1)});
                end
            end
        end
        checks++;
        if (stab_err != 0) begin
            failures++;
            $display("FAIL bp_stable: got %0d changes while stalled, required 0", stab_err);
        end
        checks++;
        if (sready_low == 0) begin
            failures++;
            $display("FAIL bp_s_ready: got 0 low cycles, required s_ready to drop");
        end
        checks++;
        if (chks.size() != 1 || chks[0] !== {1'b1, 1'b0, 16'd6}) begin
            failures++;
            $display("FAIL bp_chk: got n=%0d st=%h, required ok len 6", chks.size(), chks.size() > 0 ? chks[0] : 18'h0);
        end
    endtask

    task automatic test_reset_abort();
        clear_q();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_m_valid: got %b after reset, required 0", m_valid);
        end
        beats.delete();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h06, 1'b1);
        idle(4);
        checks++;
        if (beats.size() != 2 || beats[0] !== 9'h000 || beats[1] !== 9'h100) begin
            failures++;
            $display("FAIL abort_beats: got n=%0d, required 000 then 100", beats.size());
        end
        checks++;
        if (chks.size() != 1 || chks[0] !== {1'b1, 1'b0, 16'd2}) begin
            failures++;
            $display("FAIL abort_chk: got n=%0d st=%h, required one ok len 2", chks.size(), chks.size() > 0 ? chks[0] : 18'h0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_crc();
        test_runt();
        test_backpressure();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
